// File: rtl/alu_pkg.sv
// Shared types for the carry-lookahead ALU back-end: 4-bit group width and group propagate/generate pair.
package alu_pkg;

   localparam int GRP_W = 4;

   typedef logic [GRP_W-1:0] grp_t;

   typedef struct packed {
      logic P;
      logic G;
   } grp_pg_t;

   // Group propagate/generate, shared by the stage-1 precompute and the stage-2 group cells.
   function automatic grp_pg_t grp_pg(input grp_t p, input grp_t g);
      grp_pg_t r;
      r.P = &p;
      r.G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      return r;
   endfunction

endpackage

// File: rtl/alu_cla_group.sv
// 4-bit lookahead cell: carries into each of its four bits plus the group propagate/generate pair.
module alu_cla_group
   import alu_pkg::*;
(
   input  grp_t    p,
   input  grp_t    g,
   input  logic    cin,
   output grp_t    c,
   output grp_pg_t pg
);

   always_comb begin
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   end

   assign pg = grp_pg(p, g);

endmodule

// File: rtl/alu_cla_pipe.sv
// Two-stage carry-lookahead ALU back-end with valid/ready flow control on both sides.
// Define ALU_STATUS_FLAGS_EN to add registered zero/ovf outputs.
module alu_cla_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] p,
   input  logic [WIDTH-1:0] g,
   input  logic             cin,
   input  logic             m,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             cout,
   output logic             gp,
   output logic             gg
`ifdef ALU_STATUS_FLAGS_EN
   ,
   output logic             zero,
   output logic             ovf
`endif
);

   localparam int NGRP = WIDTH / GRP_W;

   if (WIDTH % GRP_W != 0) begin : g_width_chk
      $error("alu_cla_pipe: WIDTH (%0d) must be a multiple of %0d", WIDTH, GRP_W);
   end

   logic                  adv_p2;
   logic                  in_fire;
   grp_pg_t [NGRP-1:0]    pg_in;

   logic                  vld_p1;
   logic [WIDTH-1:0]      p_p1;
   logic [WIDTH-1:0]      g_p1;
   logic                  cin_p1;
   logic                  m_p1;
   grp_pg_t [NGRP-1:0]    pg_p1;

   logic [NGRP:0]         grp_c;
   logic [WIDTH-1:0]      bit_c;
   grp_pg_t [NGRP-1:0]    pg_s2;
   logic [WIDTH-1:0]      f_d;
   logic                  cout_d;
   logic                  gp_d;
   logic                  gg_d;

   assign adv_p2   = ~out_valid | out_ready;
   assign in_ready = ~vld_p1 | adv_p2;
   assign in_fire  = in_valid & in_ready;

   always_comb begin
      for (int k = 0; k < NGRP; k++) begin
         pg_in[k] = grp_pg(p[k*GRP_W +: GRP_W], g[k*GRP_W +: GRP_W]);
      end
   end

   // ---- stage 1 boundary: register operands and per-group P/G ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
      end else if (in_ready) begin
         vld_p1 <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire) begin
         p_p1   <= p;
         g_p1   <= g;
         cin_p1 <= cin;
         m_p1   <= m;
         pg_p1  <= pg_in;
      end
   end

   // Second-level lookahead: group carries come only from the registered P/G pairs and cin.
   always_comb begin
      grp_c[0] = cin_p1;
      for (int k = 0; k < NGRP; k++) begin
         grp_c[k+1] = pg_p1[k].G | (pg_p1[k].P & grp_c[k]);
      end
   end

   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      alu_cla_group u_grp (
         .p   (p_p1[k*GRP_W +: GRP_W]),
         .g   (g_p1[k*GRP_W +: GRP_W]),
         .cin (grp_c[k]),
         .c   (bit_c[k*GRP_W +: GRP_W]),
         .pg  (pg_s2[k])
      );
   end

   // Word-level P/G ignores cin and m so it can feed an external lookahead level.
   always_comb begin
      gp_d = 1'b1;
      gg_d = 1'b0;
      for (int k = 0; k < NGRP; k++) begin
         gp_d = gp_d & pg_s2[k].P;
         gg_d = pg_s2[k].G | (pg_s2[k].P & gg_d);
      end
   end

   assign f_d    = (p_p1 & ~g_p1) ^ (bit_c & {WIDTH{~m_p1}});
   assign cout_d = grp_c[NGRP] & ~m_p1;

   // ---- stage 2 boundary: registered result bus ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         f         <= '0;
         cout      <= 1'b0;
         gp        <= 1'b0;
         gg        <= 1'b0;
      end else if (adv_p2) begin
         out_valid <= vld_p1;
         if (vld_p1) begin
            f    <= f_d;
            cout <= cout_d;
            gp   <= gp_d;
            gg   <= gg_d;
         end
      end
   end

`ifdef ALU_STATUS_FLAGS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero <= 1'b0;
         ovf  <= 1'b0;
      end else if (adv_p2 && vld_p1) begin
         zero <= ~|f_d;
         ovf  <= ~m_p1 & (grp_c[NGRP] ^ bit_c[WIDTH-1]);
      end
   end
`endif

endmodule

// File: tb/tb_alu_cla_pipe.sv
// Self-checking bench for alu_cla_pipe: directed cases, backpressure, mid-stream reset, random traffic.
// Flag checks are compiled in when ALU_STATUS_FLAGS_EN is defined.
module tb_alu_cla_pipe;

   localparam int WIDTH = 16;

   typedef struct {
      logic [WIDTH-1:0] f;
      logic             cout;
      logic             gp;
      logic             gg;
      logic             zero;
      logic             ovf;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_drv;
   logic [WIDTH-1:0] b_drv;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] g;
   logic             cin;
   logic             m;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] f;
   logic             cout;
   logic             gp;
   logic             gg;
`ifdef ALU_STATUS_FLAGS_EN
   logic             zero;
   logic             ovf;
`endif

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_out    = 0;
   int   mark;
   exp_t q[$];
   exp_t mon_e;
   exp_t hold_e;
   logic hold_v    = 1'b0;
   logic in_fire_q = 1'b0;

   assign p = a_drv | b_drv;
   assign g = a_drv & b_drv;

   always #5 clk = ~clk;

   alu_cla_pipe #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .p         (p),
      .g         (g),
      .cin       (cin),
      .m         (m),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .f         (f),
      .cout      (cout),
      .gp        (gp),
      .gg        (gg)
`ifdef ALU_STATUS_FLAGS_EN
      ,
      .zero      (zero),
      .ovf       (ovf)
`endif
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference: plain integer addition on the operands the front-end encoded as p=a|b, g=a&b.
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic c, input logic mm);
      exp_t           r;
      logic [WIDTH:0] sum;
      logic [WIDTH:0] sum0;
      sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
      sum0   = {1'b0, a} + {1'b0, b};
      r.f    = mm ? (a ^ b) : sum[WIDTH-1:0];
      r.cout = ~mm & sum[WIDTH];
      r.gp   = &(a | b);
      r.gg   = sum0[WIDTH];
      r.zero = (r.f == '0);
      r.ovf  = ~mm & (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         hold_v    = 1'b0;
         in_fire_q = 1'b0;
      end else begin
         if (hold_v) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_f",     32'(f),         32'(hold_e.f));
            check("hold_cout",  32'(cout),      32'(hold_e.cout));
         end
         if (out_valid && out_ready) begin
            check("out_has_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               mon_e = q.pop_front();
               n_out++;
               check("f",    32'(f),    32'(mon_e.f));
               check("cout", 32'(cout), 32'(mon_e.cout));
               check("gp",   32'(gp),   32'(mon_e.gp));
               check("gg",   32'(gg),   32'(mon_e.gg));
`ifdef ALU_STATUS_FLAGS_EN
               check("zero", 32'(zero), 32'(mon_e.zero));
               check("ovf",  32'(ovf),  32'(mon_e.ovf));
`endif
            end
         end
         hold_v = out_valid && !out_ready;
         if (hold_v) begin
            hold_e.f    = f;
            hold_e.cout = cout;
         end
         in_fire_q = in_valid && in_ready;
         if (in_fire_q) q.push_back(model(a_drv, b_drv, cin, m));
      end
   end

   // Called just after a rising edge; returns just after the edge that accepted the word.
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic mm);
      logic acc;
      acc      = 1'b0;
      a_drv    = a;
      b_drv    = b;
      cin      = c;
      m        = mm;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      in_valid = 1'b0;
      check("accept", 32'(acc), 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
      #1;
      check("drained", 32'(q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a_drv     = '0;
      b_drv     = '0;
      cin       = 1'b0;
      m         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_f",         32'(f),         32'd0);
      check("rst_cout",      32'(cout),      32'd0);
      check("rst_gp_gg",     32'({gp, gg}),  32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef ALU_STATUS_FLAGS_EN
      check("rst_flags",     32'({zero, ovf}), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      send(16'h1234, 16'h4321, 1'b0, 1'b0);
      check("add_lat1_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("add_lat2_valid", 32'(out_valid), 32'd1);
      check("add_f",          32'(f),         32'h5555);
      check("add_cout",       32'(cout),      32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("bubble_valid",   32'(out_valid), 32'd0);
      check("bubble_f_hold",  32'(f),         32'h5555);

      send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      @(posedge clk); #1;
      check("ripple_f",     32'(f),             32'h0000);
      check("ripple_cout",  32'(cout),          32'd1);
      check("ripple_gp_gg", 32'({gp, gg}),      32'b10);
`ifdef ALU_STATUS_FLAGS_EN
      check("ripple_flags", 32'({zero, ovf}),   32'b10);
`endif

      send(16'hF0F0, 16'h0FF0, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("logic_f",    32'(f),    32'hFF00);
      check("logic_cout", 32'(cout), 32'd0);

      send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("ovf_f", 32'(f), 32'h8000);
`ifdef ALU_STATUS_FLAGS_EN
      check("ovf_flags", 32'({zero, ovf}), 32'b01);
`endif
      drain();

      mark      = n_out;
      out_ready = 1'b0;
      send(16'h0101, 16'h0202, 1'b0, 1'b0);
      send(16'h8000, 16'h8000, 1'b0, 1'b0);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      fork
         begin
            send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
            send(16'h00FF, 16'h0F0F, 1'b0, 1'b1);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_delivered", 32'(n_out - mark), 32'd4);

      for (int i = 0; i < 400; i++) begin
         if (!in_valid || in_fire_q) begin
            a_drv    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            b_drv    = ($urandom_range(0, 7) == 0) ? ~a_drv   : 16'($urandom);
            cin      = 1'($urandom);
            m        = ($urandom_range(0, 3) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      out_ready = 1'b0;
      send(16'h1111, 16'h2222, 1'b0, 1'b0);
      send(16'h3333, 16'h4444, 1'b0, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_f",         32'(f),         32'd0);
      check("midrst_cout",      32'(cout),      32'd0);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      mark = n_out;
      send(16'h0001, 16'h0002, 1'b0, 1'b0);
      check("post_rst_lat1", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("post_rst_lat2", 32'(out_valid), 32'd1);
      check("post_rst_f",    32'(f),         32'h0003);
      drain();
      check("post_rst_count", 32'(n_out - mark), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
